// File: rtl/mold_arb_pkg.sv
// rtl/mold_arb_pkg.sv - shared types and constants for the MoldUDP64 A/B feed arbiter.
package mold_arb_pkg;

  localparam logic [15:0] MOLD_HEARTBEAT_CNT = 16'h0000;
  localparam logic [15:0] MOLD_EOS_CNT       = 16'hFFFF;

  typedef enum logic {LANE_A, LANE_B} laneType;

  typedef enum logic [1:0] {IDLE, FWD_A, FWD_B} arbStateType;

  typedef enum logic [2:0] {CLS_CTRL, CLS_DUP, CLS_GAP, CLS_OK, CLS_BUSY} frameClassType;

  function automatic logic is_accept(input frameClassType cls);
    return (cls == CLS_OK) || (cls == CLS_GAP);
  endfunction

endpackage

// File: rtl/mold_lane_eval.sv
// rtl/mold_lane_eval.sv - classifies one lane's start-of-frame against the expected sequence.
module mold_lane_eval
  import mold_arb_pkg::*;
#(
  parameter int SEQ_W = 64
) (
  input  logic [SEQ_W-1:0] seq_i,
  input  logic [15:0]      msg_cnt_i,
  input  logic [SEQ_W-1:0] exp_seq_i,
  input  logic             synced_i,
  input  logic             busy_i,
  output frameClassType    cls_o,
  output logic [SEQ_W-1:0] end_o
);

  assign end_o = seq_i + {{(SEQ_W-16){1'b0}}, msg_cnt_i};

  always_comb begin
    cls_o = CLS_OK;
    if (msg_cnt_i == MOLD_HEARTBEAT_CNT || msg_cnt_i == MOLD_EOS_CNT) begin
      cls_o = CLS_CTRL;
    end else if (busy_i) begin
      cls_o = (end_o <= exp_seq_i) ? CLS_DUP : CLS_BUSY;
    end else if (!synced_i) begin
      cls_o = CLS_OK;
    end else if (end_o <= exp_seq_i) begin
      cls_o = CLS_DUP;
    end else if (seq_i > exp_seq_i) begin
      cls_o = CLS_GAP;
    end
  end

endmodule

// File: rtl/mold_feed_arbiter.sv
// rtl/mold_feed_arbiter.sv - forwards the first copy of each MoldUDP64 range from the A/B feeds.
module mold_feed_arbiter
  import mold_arb_pkg::*;
#(
  parameter int SEQ_W = 64,
  parameter int CNT_W = 32
) (
  input  logic             clkIn,
  input  logic             rstNIn,
  input  logic [1:0]       laneEnIn,
  input  logic [7:0]       aDataIn,
  input  logic             aDataValidIn,
  input  logic             aSofIn,
  input  logic [SEQ_W-1:0] aSeqNumIn,
  input  logic [15:0]      aMsgCntIn,
  input  logic [7:0]       bDataIn,
  input  logic             bDataValidIn,
  input  logic             bSofIn,
  input  logic [SEQ_W-1:0] bSeqNumIn,
  input  logic [15:0]      bMsgCntIn,
  output logic [7:0]       itchDataOut,
  output logic             itchDataValidOut,
  output logic             itchSofOut,
  output logic             srcLaneOut,
  output logic [SEQ_W-1:0] expSeqNumOut,
  output logic             syncedOut,
  output logic             gapOut,
  output logic [CNT_W-1:0] gapCntOut,
  output logic [CNT_W-1:0] dupCntOut,
  output logic [CNT_W-1:0] busyDropCntOut
);

  arbStateType      state_q, state_d;
  logic [SEQ_W-1:0] exp_q, exp_mid, a_end, b_end;
  logic             synced_q, synced_mid;
  logic [7:0]       data_q;
  logic             valid_q, sof_q, src_q, gap_q;
  logic [CNT_W-1:0] gap_cnt_q, dup_cnt_q, busy_cnt_q;
  frameClassType    a_cls, b_cls;
  logic             a_sof, b_sof, a_cont, b_cont, a_acc, b_acc, fwd_a, fwd_b, gap_ev;
  logic [1:0]       dup_inc, busy_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign a_sof = laneEnIn[0] & aSofIn & aDataValidIn;
  assign b_sof = laneEnIn[1] & bSofIn & bDataValidIn;

  // A lane keeps ownership only while its frame continues; a raw SOF ends the old frame.
  assign a_cont = (state_q == FWD_A) & aDataValidIn & ~aSofIn;
  assign b_cont = (state_q == FWD_B) & bDataValidIn & ~bSofIn;

  mold_lane_eval #(.SEQ_W(SEQ_W)) u_eval_a (
    .seq_i    (aSeqNumIn),
    .msg_cnt_i(aMsgCntIn),
    .exp_seq_i(exp_q),
    .synced_i (synced_q),
    .busy_i   (b_cont),
    .cls_o    (a_cls),
    .end_o    (a_end)
  );

  assign a_acc      = a_sof & is_accept(a_cls);
  assign exp_mid    = a_acc ? a_end : exp_q;
  assign synced_mid = synced_q | a_acc;

  // B sees A's decision from this same cycle, so a simultaneous copy lands as a duplicate.
  mold_lane_eval #(.SEQ_W(SEQ_W)) u_eval_b (
    .seq_i    (bSeqNumIn),
    .msg_cnt_i(bMsgCntIn),
    .exp_seq_i(exp_mid),
    .synced_i (synced_mid),
    .busy_i   (a_cont | a_acc),
    .cls_o    (b_cls),
    .end_o    (b_end)
  );

  assign b_acc    = b_sof & is_accept(b_cls);
  assign fwd_a    = a_acc | a_cont;
  assign fwd_b    = b_acc | b_cont;
  assign gap_ev   = (a_acc & (a_cls == CLS_GAP)) | (b_acc & (b_cls == CLS_GAP));
  assign dup_inc  = {1'b0, a_sof & (a_cls == CLS_DUP)} + {1'b0, b_sof & (b_cls == CLS_DUP)};
  assign busy_inc = {1'b0, a_sof & (a_cls == CLS_BUSY)} + {1'b0, b_sof & (b_cls == CLS_BUSY)};

  always_comb begin
    state_d = IDLE;
    if (a_acc)       state_d = FWD_A;
    else if (b_acc)  state_d = FWD_B;
    else if (a_cont) state_d = FWD_A;
    else if (b_cont) state_d = FWD_B;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      synced_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      src_q      <= 1'b0;
      gap_q      <= 1'b0;
      gap_cnt_q  <= '0;
      dup_cnt_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= b_acc ? b_end : exp_mid;
      synced_q   <= synced_mid | b_acc;
      valid_q    <= fwd_a | fwd_b;
      data_q     <= fwd_a ? aDataIn : (fwd_b ? bDataIn : 8'h00);
      sof_q      <= a_acc | b_acc;
      src_q      <= fwd_b;
      gap_q      <= gap_ev;
      gap_cnt_q  <= sat_add(gap_cnt_q, {1'b0, gap_ev});
      dup_cnt_q  <= sat_add(dup_cnt_q, dup_inc);
      busy_cnt_q <= sat_add(busy_cnt_q, busy_inc);
    end
  end

  assign itchDataOut      = data_q;
  assign itchDataValidOut = valid_q;
  assign itchSofOut       = sof_q;
  assign srcLaneOut       = src_q;
  assign expSeqNumOut     = exp_q;
  assign syncedOut        = synced_q;
  assign gapOut           = gap_q;
  assign gapCntOut        = gap_cnt_q;
  assign dupCntOut        = dup_cnt_q;
  assign busyDropCntOut   = busy_cnt_q;

endmodule

// File: tb/tb_mold_feed_arbiter.sv
// tb/tb_mold_feed_arbiter.sv - self-checking bench for the MoldUDP64 A/B feed arbiter.
module tb_mold_feed_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = 2'b11;
  logic [7:0]  a_d = '0, b_d = '0;
  logic        a_v = 1'b0, a_s = 1'b0, b_v = 1'b0, b_s = 1'b0;
  logic [63:0] a_seq = '0, b_seq = '0;
  logic [15:0] a_cnt = '0, b_cnt = '0;

  logic [7:0]  o_d;
  logic        o_v, o_sof, o_src, o_sync, o_gap;
  logic [63:0] o_exp;
  logic [31:0] o_gapc, o_dupc, o_busyc;

  always #2 clk = ~clk;

  mold_feed_arbiter #(.SEQ_W(64), .CNT_W(32)) dut (
    .clkIn(clk), .rstNIn(rst_n), .laneEnIn(en),
    .aDataIn(a_d), .aDataValidIn(a_v), .aSofIn(a_s), .aSeqNumIn(a_seq), .aMsgCntIn(a_cnt),
    .bDataIn(b_d), .bDataValidIn(b_v), .bSofIn(b_s), .bSeqNumIn(b_seq), .bMsgCntIn(b_cnt),
    .itchDataOut(o_d), .itchDataValidOut(o_v), .itchSofOut(o_sof), .srcLaneOut(o_src),
    .expSeqNumOut(o_exp), .syncedOut(o_sync), .gapOut(o_gap),
    .gapCntOut(o_gapc), .dupCntOut(o_dupc), .busyDropCntOut(o_busyc)
  );

  int checks = 0;
  int errors = 0;
  int bytes_a = 0, bytes_b = 0, gap_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: who owns the output, what sequence comes next, and what each SOF earns.
  logic [7:0]  m_d;
  logic        m_v, m_sof, m_src, m_gap, m_sync;
  logic [63:0] m_exp;
  logic [31:0] m_gapc, m_dupc, m_busyc;
  int          m_own;

  function automatic logic [31:0] sat(input logic [31:0] c, input int n);
    longint s;
    s = longint'(c) + n;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : c + 32'(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [63:0] e, endv;
    logic        s, nsof, ngap;
    int          own, dup_n, busy_n, gap_n;
    logic [63:0] sq[2];
    logic [15:0] cn[2];
    logic        vv[2], sf[2];
    if (!rst_n) begin
      m_d <= '0; m_v <= 0; m_sof <= 0; m_src <= 0; m_gap <= 0; m_sync <= 0;
      m_exp <= '0; m_gapc <= '0; m_dupc <= '0; m_busyc <= '0; m_own <= 0;
    end else begin
      e = m_exp; s = m_sync; own = m_own;
      dup_n = 0; busy_n = 0; gap_n = 0; nsof = 0; ngap = 0;
      sq[0] = a_seq; cn[0] = a_cnt; vv[0] = a_v; sf[0] = a_s;
      sq[1] = b_seq; cn[1] = b_cnt; vv[1] = b_v; sf[1] = b_s;
      for (int l = 0; l < 2; l++)
        if (own == l + 1 && (!vv[l] || sf[l])) own = 0;
      for (int l = 0; l < 2; l++) begin
        if (en[l] && sf[l] && vv[l] && cn[l] != 16'h0000 && cn[l] != 16'hFFFF) begin
          endv = sq[l] + {48'b0, cn[l]};
          if (own != 0) begin
            if (endv <= e) dup_n++; else busy_n++;
          end else if (!s) begin
            own = l + 1; e = endv; s = 1; nsof = 1;
          end else if (endv <= e) begin
            dup_n++;
          end else begin
            ngap = (sq[l] > e);
            if (ngap) gap_n++;
            own = l + 1; e = endv; nsof = 1;
          end
        end
      end
      if (own == 1 && vv[0]) begin
        m_v <= 1; m_d <= a_d; m_src <= 0;
      end else if (own == 2 && vv[1]) begin
        m_v <= 1; m_d <= b_d; m_src <= 1;
      end else begin
        m_v <= 0; m_d <= '0; m_src <= 0;
      end
      m_own <= own; m_exp <= e; m_sync <= s; m_sof <= nsof; m_gap <= ngap;
      m_gapc <= sat(m_gapc, gap_n);
      m_dupc <= sat(m_dupc, dup_n);
      m_busyc <= sat(m_busyc, busy_n);
    end
  end

  always @(negedge clk) begin
    chk("valid", {63'b0, o_v}, {63'b0, m_v});
    if (m_v) begin
      chk("data", {56'b0, o_d}, {56'b0, m_d});
      chk("src", {63'b0, o_src}, {63'b0, m_src});
    end
    chk("sof", {63'b0, o_sof}, {63'b0, m_sof});
    chk("gap", {63'b0, o_gap}, {63'b0, m_gap});
    chk("exp_seq", o_exp, m_exp);
    chk("synced", {63'b0, o_sync}, {63'b0, m_sync});
    chk("gap_cnt", {32'b0, o_gapc}, {32'b0, m_gapc});
    chk("dup_cnt", {32'b0, o_dupc}, {32'b0, m_dupc});
    chk("busy_cnt", {32'b0, o_busyc}, {32'b0, m_busyc});
    if (o_v && !o_src) bytes_a++;
    if (o_v && o_src) bytes_b++;
    if (o_gap) gap_pulses++;
  end

  int          left[2] = '{0, 0};
  int          idx[2] = '{0, 0};
  logic [63:0] fseq[2];
  logic [15:0] fcnt[2];

  task automatic start(input int l, input logic [63:0] sq, input logic [15:0] c, input int len);
    left[l] = len; idx[l] = 0; fseq[l] = sq; fcnt[l] = c;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_v = left[0] > 0; a_s = (left[0] > 0) && (idx[0] == 0);
      a_d = 8'(idx[0]) + 8'h10; a_seq = fseq[0]; a_cnt = fcnt[0];
      b_v = left[1] > 0; b_s = (left[1] > 0) && (idx[1] == 0);
      b_d = 8'(idx[1]) + 8'h80; b_seq = fseq[1]; b_cnt = fcnt[1];
      for (int l = 0; l < 2; l++)
        if (left[l] > 0) begin left[l]--; idx[l]++; end
    end
  endtask

  int ba, bb, gp;

  task automatic mark();
    ba = bytes_a; bb = bytes_b; gp = gap_pulses;
  endtask

  initial begin
    fseq[0] = '0; fseq[1] = '0; fcnt[0] = '0; fcnt[1] = '0;
    run(3);
    chk("reset_valid", {63'b0, o_v}, 64'd0);
    chk("reset_synced", {63'b0, o_sync}, 64'd0);
    chk("reset_exp", o_exp, 64'd0);
    rst_n = 1'b1;

    mark(); start(0, 64'd0, 16'd1, 36); run(40);
    chk("s1_bytes_a", 64'(bytes_a - ba), 64'd36);
    chk("s1_bytes_b", 64'(bytes_b - bb), 64'd0);
    chk("s1_synced", {63'b0, o_sync}, 64'd1);
    chk("s1_exp", o_exp, 64'd1);
    chk("s1_gap_pulses", 64'(gap_pulses - gp), 64'd0);

    mark(); start(0, 64'd1, 16'd1, 20); run(10); start(1, 64'd1, 16'd1, 20); run(25);
    chk("s2_bytes_a", 64'(bytes_a - ba), 64'd20);
    chk("s2_bytes_b", 64'(bytes_b - bb), 64'd0);
    chk("s2_dup", {32'b0, o_dupc}, 64'd1);
    chk("s2_exp", o_exp, 64'd2);

    mark(); start(0, 64'd2, 16'd3, 8); start(1, 64'd2, 16'd3, 8); run(12);
    chk("s3_bytes_a", 64'(bytes_a - ba), 64'd8);
    chk("s3_bytes_b", 64'(bytes_b - bb), 64'd0);
    chk("s3_exp", o_exp, 64'd5);
    chk("s3_dup", {32'b0, o_dupc}, 64'd2);

    mark(); start(1, 64'd9, 16'd2, 10); run(14);
    chk("s4_bytes_b", 64'(bytes_b - bb), 64'd10);
    chk("s4_gap_pulses", 64'(gap_pulses - gp), 64'd1);
    chk("s4_gap_cnt", {32'b0, o_gapc}, 64'd1);
    chk("s4_exp", o_exp, 64'd11);

    mark(); start(0, 64'd11, 16'd1, 16); run(4); start(1, 64'd12, 16'd1, 6); run(16);
    chk("s5_bytes_a", 64'(bytes_a - ba), 64'd16);
    chk("s5_bytes_b", 64'(bytes_b - bb), 64'd0);
    chk("s5_busy", {32'b0, o_busyc}, 64'd1);
    chk("s5_exp", o_exp, 64'd12);

    mark(); start(0, 64'd13, 16'd0, 8); run(10);
    chk("s6_hb_bytes", 64'(bytes_a + bytes_b - ba - bb), 64'd0);
    chk("s6_hb_exp", o_exp, 64'd12);
    chk("s6_hb_dup", {32'b0, o_dupc}, 64'd2);

    start(1, 64'd13, 16'd1, 30); run(6);
    chk("s6_b_gap_cnt", {32'b0, o_gapc}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'b0, o_v}, 64'd0);
    chk("rst_exp", o_exp, 64'd0);
    chk("rst_synced", {63'b0, o_sync}, 64'd0);
    chk("rst_gap_cnt", {32'b0, o_gapc}, 64'd0);
    chk("rst_dup_cnt", {32'b0, o_dupc}, 64'd0);
    chk("rst_busy_cnt", {32'b0, o_busyc}, 64'd0);
    run(3);
    rst_n = 1'b1;
    mark(); run(25);
    chk("post_rst_bytes", 64'(bytes_a + bytes_b - ba - bb), 64'd0);
    chk("post_rst_synced", {63'b0, o_sync}, 64'd0);

    mark(); start(0, 64'd0, 16'd1, 10); run(3); en = 2'b10; run(12);
    chk("en_off_bytes_a", 64'(bytes_a - ba), 64'd10);
    chk("en_off_exp", o_exp, 64'd1);
    mark(); start(0, 64'd1, 16'd1, 5); run(8);
    chk("en_off_ignored", 64'(bytes_a - ba), 64'd0);

    en = 2'b11;
    mark(); start(0, 64'd5, 16'd0, 6); start(1, 64'd1, 16'd1, 6); run(9);
    chk("hb_a_bytes_b", 64'(bytes_b - bb), 64'd6);
    chk("hb_a_exp", o_exp, 64'd2);
    chk("hb_a_dup", {32'b0, o_dupc}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mold_feed_arbiter.md
Name: mold_feed_arbiter

Overview:
- Line arbiter between two redundant eth_udp_parser instances (NASDAQ A/B feeds) carrying the same MoldUDP64 session.
- Per frame, forwards the first copy of each sequence range to the single ITCH byte output and drops duplicates.
- Tracks the expected sequence number and flags gaps.
- Sits between the two parsers and the ITCH message decoder / book.

Parameters:
- SEQ_W, 64, MoldUDP64 sequence number width.
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clkIn, input, 1, 250 MHz clock.
- rstNIn, input, 1, asynchronous active-low reset.
- laneEnIn, input, 2, per-lane enable; bit0 = A, bit1 = B.
- aDataIn, input, 8, lane A ITCH byte.
- aDataValidIn, input, 1, lane A byte valid; high contiguously for a whole frame.
- aSofIn, input, 1, lane A first byte of frame; qualifies aSeqNumIn and aMsgCntIn.
- aSeqNumIn, input, SEQ_W, lane A Mold seqNum of the frame.
- aMsgCntIn, input, 16, lane A Mold msgCnt of the frame.
- bDataIn, bDataValidIn, bSofIn, bSeqNumIn, bMsgCntIn: same as lane A, for lane B.
- itchDataOut, output, 8, forwarded byte.
- itchDataValidOut, output, 1, forwarded byte valid.
- itchSofOut, output, 1, first forwarded byte of frame.
- srcLaneOut, output, 1, 0 = A, 1 = B; valid with itchDataValidOut.
- expSeqNumOut, output, SEQ_W, next expected sequence number.
- syncedOut, output, 1, expected sequence established.
- gapOut, output, 1, one-cycle pulse when an accepted frame skips sequence numbers.
- gapCntOut, output, CNT_W, gap event count.
- dupCntOut, output, CNT_W, duplicate frames dropped.
- busyDropCntOut, output, CNT_W, new frames dropped because output was busy.

Behaviour:
- Reset (asynchronous, rstNIn = 0):
  - All outputs 0, including syncedOut and expSeqNumOut.
  - State IDLE; per-lane discard flags cleared.
- States:
  - IDLE: no lane owns the output.
  - FWD_A / FWD_B: that lane owns the output.
- Latency: output is registered; a byte presented at cycle n appears at n+1 with itchSofOut/srcLaneOut aligned to it.
- Frame evaluation:
  - Happens only on a cycle where laneEn & xSofIn & xDataValidIn.
  - Bytes of a lane without a prior evaluated SOF are ignored. This covers a frame already in progress at reset release or when the lane is enabled.
  - end = seq + msgCnt, computed at SEQ_W, wrap ignored.
- Classification, in priority order:
  1. msgCnt == 0x0000 (heartbeat) or 0xFFFF (end of session): discard, no counter change.
  2. Output owned by the other lane: if end <= expSeq, discard with dupCnt++; otherwise discard with busyDropCnt++.
  3. !synced: accept; synced <= 1.
  4. end <= expSeq: duplicate; discard; dupCnt++.
  5. seq > expSeq: accept; pulse gapOut on the first output byte; gapCnt++.
  6. Otherwise (seq <= expSeq < end, contiguous or overlapping): accept; the whole frame is forwarded.
- On accept:
  - expSeq <= end in the SOF cycle.
  - State <= FWD_x.
- FWD_x:
  - Forward every valid byte of lane x.
  - xDataValidIn low: return to IDLE in the same cycle, so a SOF on the other lane in that cycle is evaluated as IDLE.
  - A new SOF on lane x while in FWD_x (back-to-back frame) is re-evaluated under the rules above, treating the output as idle.
- Simultaneous SOF in IDLE:
  - Lane A is evaluated first.
  - If A is accepted, B is evaluated against A's updated end.
  - If A is discarded, B is evaluated normally.
- laneEnIn deasserted mid-frame: the frame in progress completes; later SOFs on that lane are ignored.
- Counters saturate at all-ones.
- Disabled or discarding lanes never drive the output.

Decomposition:
- Package mold_arb_pkg:
  - MOLD_HEARTBEAT_CNT = 16'h0000, MOLD_EOS_CNT = 16'hFFFF.
  - laneType enum {LANE_A, LANE_B}.
  - arbStateType enum {IDLE, FWD_A, FWD_B}.
  - frameClassType enum {CLS_CTRL, CLS_DUP, CLS_GAP, CLS_OK, CLS_BUSY}.
- Sub-module mold_lane_eval, instantiated twice:
  - Combinational classification of one lane's SOF given expSeq, synced and busy.
  - Outputs frameClassType and end.
  - The top level owns the FSM, expSeq and the counters.

Test Plan:
- Reset, then A SOF seq = 0, cnt = 1, 36 bytes -> 36 bytes out, srcLaneOut = 0, syncedOut = 1, expSeqNumOut = 1, gapOut never high.
- A seq = 1, cnt = 1 at t0; B same frame starting 10 cycles later -> only A forwarded; dupCntOut = 1; expSeqNumOut = 2.
- Both SOF same cycle, seq = 2, cnt = 3 -> A forwarded, B dropped as duplicate; expSeqNumOut = 5; dupCntOut += 1.
- After expSeq = 5, B SOF seq = 9, cnt = 2 -> forwarded with srcLaneOut = 1; one-cycle gapOut on first byte; gapCntOut = 1; expSeqNumOut = 11.
- While A is forwarding seq = 11, cnt = 1, B SOF seq = 12, cnt = 1 -> B dropped; busyDropCntOut = 1; A frame intact.
- Heartbeat A seq = 13, cnt = 0 -> no output and no counter change. Then assert rstNIn low mid-frame on B -> all outputs 0 immediately; the remainder of B's frame is ignored after release.
